// File: rtl/serial_operand_serializer.sv
// rtl/serial_operand_serializer.sv - parallel operand pair to LSB-first bit-pair stream
// Feeds the bit-serial adder; first/last mark word boundaries, back-to-back words load without a bubble.
module serial_operand_serializer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         en,
  output logic         out_valid,
  output logic         a,
  output logic         b,
  output logic         first,
  output logic         last
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  sh_a_q, sh_a_d;
  logic [W-1:0]  sh_b_q, sh_b_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic at_last;
  logic adv;
  logic load;

  always_comb begin
    out_valid = (state_q == SHIFT);
    at_last   = (cnt_q == LAST_IDX);
    adv       = out_valid && en && at_last;
    // Held low while reset is asserted so nothing upstream sees a handshake.
    in_ready  = rst && ((state_q == IDLE) || adv);
    load      = in_valid && in_ready;

    a         = out_valid & sh_a_q[0];
    b         = out_valid & sh_b_q[0];
    first     = out_valid && (cnt_q == '0);
    last      = out_valid && at_last;
  end

  always_comb begin
    state_d = state_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (load) begin
          state_d = SHIFT;
          sh_a_d  = in_a;
          sh_b_d  = in_b;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (en) begin
          if (!at_last) begin
            sh_a_d = sh_a_q >> 1;
            sh_b_d = sh_b_q >> 1;
            cnt_d  = cnt_q + 1'b1;
          end else if (load) begin
            sh_a_d = in_a;
            sh_b_d = in_b;
            cnt_d  = '0;
          end else begin
            state_d = IDLE;
            sh_a_d  = '0;
            sh_b_d  = '0;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_serial_operand_serializer.sv
// tb/tb_serial_operand_serializer.sv - self-checking bench for serial_operand_serializer
// Runs a W=8 and a W=1 instance side by side against a word-level reference model.
module tb_serial_operand_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       v8, r8, e8, ov8, a8, b8, f8, l8;
  logic [7:0] ia8, ib8;
  logic       v1, r1, e1, ov1, a1, b1, f1, l1;
  logic [0:0] ia1, ib1;

  serial_operand_serializer #(.W(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8), .in_a(ia8), .in_b(ib8),
    .en(e8), .out_valid(ov8), .a(a8), .b(b8), .first(f8), .last(l8)
  );

  serial_operand_serializer #(.W(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_a(ia1), .in_b(ib1),
    .en(e1), .out_valid(ov1), .a(a1), .b(b1), .first(f1), .last(l1)
  );

  int compared   = 0;
  int mismatched = 0;
  int cyc_n      = 0;

  // Word-level model: the word being sent, which bit index is on the wire, and whether a word is active.
  bit          busy [2];
  int unsigned ma   [2];
  int unsigned mb   [2];
  int unsigned idx  [2];
  int unsigned wid  [2] = '{8, 1};

  logic [7:0] cap_a, cap_b;
  int         cap_n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] expv(input int d, input bit e);
    logic ov, ea, eb, ef, el, er;
    ov = busy[d];
    ea = busy[d] && (((ma[d] >> idx[d]) & 1) != 0);
    eb = busy[d] && (((mb[d] >> idx[d]) & 1) != 0);
    ef = busy[d] && (idx[d] == 0);
    el = busy[d] && (idx[d] == wid[d] - 1);
    er = !busy[d] || (e && idx[d] == wid[d] - 1);
    return {ov, ea, eb, ef, el, er};
  endfunction

  task automatic model_step(input int d, input bit v, input bit e,
                            input int unsigned ia, input int unsigned ib);
    if (busy[d]) begin
      if (e) begin
        if (idx[d] == wid[d] - 1) begin
          if (v) begin
            ma[d] = ia; mb[d] = ib; idx[d] = 0;
          end else begin
            busy[d] = 1'b0;
          end
        end else begin
          idx[d]++;
        end
      end
    end else if (v) begin
      busy[d] = 1'b1; ma[d] = ia; mb[d] = ib; idx[d] = 0;
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      busy[d] = 1'b0; ma[d] = 0; mb[d] = 0; idx[d] = 0;
    end
  endtask

  task automatic cyc(input bit v8i, input logic [7:0] a8i, input logic [7:0] b8i, input bit e8i,
                     input bit v1i, input bit a1i, input bit b1i, input bit e1i);
    @(negedge clk);
    v8 = v8i; ia8 = a8i; ib8 = b8i; e8 = e8i;
    v1 = v1i; ia1 = a1i; ib1 = b1i; e1 = e1i;
    #1;
    chk($sformatf("w8 cyc%0d {ov,a,b,first,last,ready}", cyc_n),
        32'({ov8, a8, b8, f8, l8, r8}), 32'(expv(0, e8i)));
    chk($sformatf("w1 cyc%0d {ov,a,b,first,last,ready}", cyc_n),
        32'({ov1, a1, b1, f1, l1, r1}), 32'(expv(1, e1i)));
    if (e8i && ov8) begin
      if (cap_n < 8) begin
        cap_a[cap_n] = a8;
        cap_b[cap_n] = b8;
      end
      cap_n++;
    end
    @(posedge clk);
    model_step(0, v8i, e8i, 32'(a8i), 32'(b8i));
    model_step(1, v1i, e1i, 32'(a1i), 32'(b1i));
    cyc_n++;
  endtask

  task automatic cyc8(input bit v, input logic [7:0] ai, input logic [7:0] bi, input bit e);
    cyc(v, ai, bi, e, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    v8 = 0; ia8 = '0; ib8 = '0; e8 = 0;
    v1 = 0; ia1 = '0; ib1 = '0; e1 = 0;
    cap_a = '0; cap_b = '0; cap_n = 0;
    model_reset();

    #1;
    chk("reset w8 outputs", 32'({ov8, a8, b8, f8, l8, r8}), 32'(6'b0));
    chk("reset w1 outputs", 32'({ov1, a1, b1, f1, l1, r1}), 32'(6'b0));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post-reset w8 in_ready", 32'(r8), 32'(1));
    chk("post-reset w1 in_ready", 32'(r1), 32'(1));

    // Idle with random garbage on the operand buses.
    repeat (10) cyc8(1'b0, 8'($urandom), 8'($urandom), 1'b1);

    // Single word, then back to idle.
    cap_n = 0;
    cyc8(1'b1, 8'h81, 8'h04, 1'b1);
    for (int i = 0; i < 8; i++) cyc8(1'b0, 8'($urandom), 8'($urandom), 1'b1);
    chk("word 81 bit count", 32'(cap_n), 32'(8));
    chk("word 81 a stream", 32'(cap_a), 32'(8'h81));
    chk("word 81 b stream", 32'(cap_b), 32'(8'h04));
    cyc8(1'b0, 8'h00, 8'h00, 1'b1);

    // Back-to-back: second pair offered on bit 7 of the first.
    cyc8(1'b1, 8'h81, 8'h04, 1'b1);
    for (int i = 0; i < 7; i++) cyc8(1'b0, 8'h00, 8'h00, 1'b1);
    cyc8(1'b1, 8'hFF, 8'h01, 1'b1);
    cap_n = 0;
    for (int i = 0; i < 8; i++) cyc8(1'b0, 8'h00, 8'h00, 1'b1);
    chk("b2b second a stream", 32'(cap_a), 32'(8'hFF));
    chk("b2b second b stream", 32'(cap_b), 32'(8'h01));

    // Stall three cycles on bit 3.
    cyc8(1'b1, 8'hA5, 8'h5A, 1'b1);
    cap_n = 0;
    for (int i = 0; i < 3; i++) cyc8(1'b0, 8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) cyc8(1'b0, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) cyc8(1'b0, 8'h00, 8'h00, 1'b1);
    chk("stall bit count", 32'(cap_n), 32'(8));
    chk("stall a stream", 32'(cap_a), 32'(8'hA5));
    chk("stall b stream", 32'(cap_b), 32'(8'h5A));

    // en low on the last bit with a pair waiting: no load until en returns.
    cyc8(1'b1, 8'h3C, 8'hC3, 1'b1);
    for (int i = 0; i < 7; i++) cyc8(1'b0, 8'h00, 8'h00, 1'b1);
    cyc8(1'b1, 8'h96, 8'h69, 1'b0);
    cyc8(1'b1, 8'h96, 8'h69, 1'b0);
    cyc8(1'b1, 8'h96, 8'h69, 1'b1);
    cap_n = 0;
    for (int i = 0; i < 8; i++) cyc8(1'b0, 8'h00, 8'h00, 1'b1);
    chk("held-ready a stream", 32'(cap_a), 32'(8'h96));

    // W=1: one pair per cycle with alternating operands.
    for (int i = 0; i < 12; i++)
      cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, ~i[0], i[0], 1'b1);
    cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Random traffic on both instances.
    repeat (400)
      cyc(1'($urandom), 8'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0),
          1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));

    // Asynchronous reset at bit 5 of a word.
    cyc8(1'b1, 8'hE7, 8'h18, 1'b1);
    for (int i = 0; i < 5; i++) cyc8(1'b0, 8'h00, 8'h00, 1'b1);
    #2;
    v8 = 0; e8 = 0; v1 = 0; e1 = 0;
    rst = 1'b0;
    #1;
    chk("mid-word reset w8 outputs", 32'({ov8, a8, b8, f8, l8, r8}), 32'(6'b0));
    chk("mid-word reset w1 outputs", 32'({ov1, a1, b1, f1, l1, r1}), 32'(6'b0));
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("release w8 in_ready", 32'(r8), 32'(1));
    cyc8(1'b1, 8'hC3, 8'h3C, 1'b1);
    cyc8(1'b0, 8'h00, 8'h00, 1'b0);
    chk("restart first", 32'(f8), 32'(1));
    cap_n = 0;
    for (int i = 0; i < 8; i++) cyc8(1'b0, 8'h00, 8'h00, 1'b1);
    chk("restart a stream", 32'(cap_a), 32'(8'hC3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/serial_operand_serializer.md
Name: serial_operand_serializer

Overview:
Upstream feeder for the bit-serial adder. It accepts two W-bit parallel operands through a valid/ready handshake and shifts them out LSB-first, one bit pair per enabled cycle, on the adder's a/b inputs. It marks word boundaries with first/last strobes; the adder stage uses first to clear its carry. A word arriving on the last bit of the current word is loaded with no bubble cycle.

Parameters:
W, 8, operand width in bits; legal range 1..32.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  asynchronous, active-low reset.
in_valid  input  1  parallel operand pair is offered.
in_ready  output  1  serializer can accept a pair this cycle; combinational.
in_a  input  W  operand A, sampled on handshake.
in_b  input  W  operand B, sampled on handshake.
en  input  1  downstream advance; the current bit pair is consumed when en && out_valid.
out_valid  output  1  a, b, first and last are meaningful.
a  output  1  current bit of A.
b  output  1  current bit of B.
first  output  1  out_valid && current bit index == 0.
last  output  1  out_valid && current bit index == W-1.

Behaviour:
- The block uses state IDLE or SHIFT, shift registers sh_a and sh_b (W bits each), and bit counter cnt of width clog2(W), minimum 1.
- While rst is low (asynchronous): state=IDLE, sh_a=sh_b=0, cnt=0. All outputs are 0 except in_ready, which is 1 once rst is released.
- Advance condition: adv = out_valid && en && cnt==W-1.
- in_ready = (state==IDLE) || adv.
- Handshake occurs on in_valid && in_ready at posedge k. It loads sh_a=in_a, sh_b=in_b, cnt=0 and sets state=SHIFT. Bit 0 is visible from posedge k until the next advance, so latency is 1 cycle.
- out_valid = (state==SHIFT).
- a = out_valid & sh_a[0] and b = out_valid & sh_b[0]. In IDLE, a and b are forced to 0.
- IDLE transitions:
  - in_valid high -> load and go to SHIFT.
  - otherwise stay in IDLE.
- SHIFT, en low: hold all state. Outputs stay stable for any number of cycles.
- SHIFT, en high, cnt<W-1: shift sh_a and sh_b right by 1 with zero fill, and increment cnt.
- SHIFT, en high, cnt==W-1:
  - in_valid high -> load the new pair, cnt=0, stay in SHIFT. The back-to-back case has no gap.
  - in_valid low -> go to IDLE, clear sh_a/sh_b, cnt=0.
- Handshake signals:
  - in_valid may rise while in_ready is low. The operands are held by the source and not sampled until ready.
  - in_a/in_b are ignored outside the handshake.
- W==1: first and last are both high on every valid cycle. in_ready tracks en while in SHIFT.
- Reset mid-word aborts the word. No partial word resumes, and the next word starts with first=1.
- Simultaneous cases:
  - en low on the last bit while in_valid is high: no load; in_ready stays 0 until en rises.
  - rst asserted always wins over any handshake.

Test Plan:
- W=8, in_a=8'h81, in_b=8'h04, en=1 held: a = 1,0,0,0,0,0,0,1 and b = 0,0,1,0,0,0,0,0 over 8 cycles. first is high in cycle 0 only, last is high in cycle 7 only, in_ready is high in cycle 7, and the block returns to IDLE after cycle 7.
- Back-to-back: second pair 8'hFF/8'h01 offered during cycle 7 of the first word -> cycle 8 shows first=1, a=1, b=1, with out_valid continuously high.
- Stall: en=0 for 3 cycles at bit index 3 of 8'hA5 -> a holds 0 (bit 3), cnt holds, and the sequence resumes at bit 4 with no bit lost or repeated.
- Reset: assert rst low at bit index 5 -> out_valid, a, b, first and last drop to 0 immediately (asynchronous). After release, in_ready=1, and a new word starts with first=1.
- Idle: in_valid=0 for 10 cycles after reset -> out_valid=0, a=b=0, in_ready=1 throughout.
- W=1 build: in_valid=1 held with en=1 and alternating operands 1/0 -> one pair accepted per cycle, first=last=1 every cycle, and a follows the accepted operands with a 1-cycle delay.
